// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial WIDTH-bit adder/subtractor.
// Computes A+B+cin (sub=0) or num1-num2-cin (sub=1) DIGIT bits per clock
// through one DIGIT-wide ripple stage, with a start/busy/done handshake.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled while not busy (IDLE or DONE)
//   sub   - 0 = add, 1 = subtract (latched with start)
//   num1  - operand A (latched with start)
//   num2  - operand B (latched with start)
//   cin   - carry-in (add) / borrow-in (sub) (latched with start)
//   busy  - operation in progress
//   done  - one-cycle pulse, results valid
//   out   - result, held until the next completed operation
//   cout  - carry out of bit WIDTH-1; in subtract mode 1 = no borrow
//   ovf   - two's-complement overflow
//   zero  - out == 0
module addsub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [DIGIT:0]   dsum_d;
  logic             cmsb_d;
  logic [WIDTH-1:0] res_d;
  logic             last_d;

  always_comb begin
    dsum_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of this digit, recovered from its sum bit;
    // on the last digit this is the carry into bit WIDTH-1.
    cmsb_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum_d[DIGIT-1];
    // New digit enters at the MSB end; after N shifts the result is aligned.
    res_d  = WIDTH'({dsum_d[DIGIT-1:0], res_q} >> DIGIT);
    last_d = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract as A + ~B + ~borrow_in.
            a_q     <= num1;
            b_q     <= sub ? ~num2 : num2;
            carry_q <= sub ? ~cin : cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dsum_d[DIGIT];
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= res_d;
            cout_q  <= dsum_d[DIGIT];
            ovf_q   <= cmsb_d ^ dsum_d[DIGIT];
            zero_q  <= (res_d == '0);
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: directed vectors on WIDTH=16/DIGIT=4 plus
// randomized sweeps on (16,16) and (8,1) against a signed/unsigned golden model.
module tb_addsub_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // WIDTH=16, DIGIT=4
  logic        start0, sub0, cin0, busy0, done0, cout0, ovf0, zero0;
  logic [15:0] a0, b0, out0;
  // WIDTH=16, DIGIT=16
  logic        start1, sub1, cin1, busy1, done1, cout1, ovf1, zero1;
  logic [15:0] a1, b1, out1;
  // WIDTH=8, DIGIT=1
  logic        start2, sub2, cin2, busy2, done2, cout2, ovf2, zero2;
  logic [7:0]  a2, b2, out2;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .sub(sub0), .num1(a0), .num2(b0),
    .cin(cin0), .busy(busy0), .done(done0), .out(out0), .cout(cout0),
    .ovf(ovf0), .zero(zero0));

  addsub_serial #(.WIDTH(16), .DIGIT(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .num1(a1), .num2(b1),
    .cin(cin1), .busy(busy1), .done(done1), .out(out1), .cout(cout1),
    .ovf(ovf1), .zero(zero1));

  addsub_serial #(.WIDTH(8), .DIGIT(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .num1(a2), .num2(b2),
    .cin(cin2), .busy(busy2), .done(done2), .out(out2), .cout(cout2),
    .ovf(ovf2), .zero(zero2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden model: arithmetic on wide signed integers, range-checked for overflow.
  function automatic void model(input int w, input bit s, input longint a, input longint b,
                                input bit ci, output longint o, output bit co,
                                output bit ov, output bit z);
    longint m, full, sa, sb, sr, hi, lo;
    m  = (longint'(1) << w) - 1;
    sa = (((a >> (w - 1)) & 1) != 0) ? a - (longint'(1) << w) : a;
    sb = (((b >> (w - 1)) & 1) != 0) ? b - (longint'(1) << w) : b;
    if (!s) begin
      full = a + b + longint'(ci);
      co   = (((full >> w) & 1) != 0);
      sr   = sa + sb + longint'(ci);
    end else begin
      full = a - b - longint'(ci);
      co   = (full >= 0);
      sr   = sa - sb - longint'(ci);
    end
    o  = full & m;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ov = (sr > hi) || (sr < lo);
    z  = (o == 0);
  endfunction

  // One operation on u0. Latency counts rising edges from start assertion
  // (the sampling edge is 1) to the edge after which done is seen.
  task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic ci, input logic [15:0] eo,
                        input logic ec, input logic eov, input logic ez, input bit glitch);
    int lat, bcnt;
    @(negedge clk);
    start0 = 1'b1; sub0 = s; a0 = a; b0 = b; cin0 = ci;
    @(posedge clk); #1;
    start0 = 1'b0;
    lat = 1; bcnt = 0;
    while (!done0 && lat < 20) begin
      if (busy0) bcnt++;
      if (glitch && lat == 2) begin
        start0 = 1'b1; sub0 = ~s; a0 = 16'hAAAA; b0 = 16'h5555; cin0 = ~ci;
      end
      if (glitch && lat == 3) start0 = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " lat"},  32'(lat),  32'd5);
    check({tag, " busy"}, 32'(bcnt), 32'd4);
    check({tag, " out"},  32'(out0), 32'(eo));
    check({tag, " cout"}, 32'(cout0), 32'(ec));
    check({tag, " ovf"},  32'(ovf0), 32'(eov));
    check({tag, " zero"}, 32'(zero0), 32'(ez));
    @(posedge clk); #1;
    check({tag, " done1cyc"}, 32'(done0), 32'd0);
  endtask

  task automatic sweep1();
    longint eo; bit ec, eov, ez, s, ci; int lat;
    logic [15:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); ci = 1'($urandom);
      model(16, s, longint'(a), longint'(b), ci, eo, ec, eov, ez);
      @(negedge clk);
      start1 = 1'b1; sub1 = s; a1 = a; b1 = b; cin1 = ci;
      @(posedge clk); #1;
      start1 = 1'b0; lat = 1;
      while (!done1 && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      check("w16d16 lat",  32'(lat),   32'd2);
      check("w16d16 out",  32'(out1),  32'(eo));
      check("w16d16 cout", 32'(cout1), 32'(ec));
      check("w16d16 ovf",  32'(ovf1),  32'(eov));
      check("w16d16 zero", 32'(zero1), 32'(ez));
    end
  endtask

  task automatic sweep2();
    longint eo; bit ec, eov, ez, s, ci; int lat;
    logic [7:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); ci = 1'($urandom);
      model(8, s, longint'(a), longint'(b), ci, eo, ec, eov, ez);
      @(negedge clk);
      start2 = 1'b1; sub2 = s; a2 = a; b2 = b; cin2 = ci;
      @(posedge clk); #1;
      start2 = 1'b0; lat = 1;
      while (!done2 && lat < 30) begin
        @(posedge clk); #1; lat++;
      end
      check("w8d1 lat",  32'(lat),   32'd9);
      check("w8d1 out",  32'(out2),  32'(eo));
      check("w8d1 cout", 32'(cout2), 32'(ec));
      check("w8d1 ovf",  32'(ovf2),  32'(eov));
      check("w8d1 zero", 32'(zero2), 32'(ez));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start0 = 0; sub0 = 0; cin0 = 0; a0 = '0; b0 = '0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    start2 = 0; sub2 = 0; cin2 = 0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy0), 32'd0);
    check("rst done", 32'(done0), 32'd0);
    check("rst out",  32'(out0),  32'd0);
    check("rst cout", 32'(cout0), 32'd0);
    check("rst ovf",  32'(ovf0),  32'd0);
    check("rst zero", 32'(zero0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add1",   1'b0, 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("addwrap",1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("addovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("subbor", 1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("subovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("subbin", 1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("glitch", 1'b0, 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: start held through DONE, second operands presented during RUN.
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b0; a0 = 16'h0100; b0 = 16'h0023; cin0 = 1'b1;
    @(posedge clk); #1;
    sub0 = 1'b1; a0 = 16'h0050; b0 = 16'h0051; cin0 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) start0 = 1'b0;
      check($sformatf("b2b done k=%0d", k), 32'(done0), 32'((k == 5) || (k == 10)));
      if (k == 5) check("b2b out1", 32'(out0), 32'h0124);
      if (k == 7) begin
        check("b2b hold out", 32'(out0), 32'h0124);
        check("b2b busy", 32'(busy0), 32'd1);
      end
      if (k == 10) begin
        check("b2b out2",  32'(out0),  32'hFFFF);
        check("b2b cout2", 32'(cout0), 32'd0);
        check("b2b ovf2",  32'(ovf0),  32'd0);
      end
      @(posedge clk); #1;
    end

    // Asynchronous reset during RUN, just after the second digit edge.
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b0; a0 = 16'h1234; b0 = 16'h0FED; cin0 = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst busy", 32'(busy0), 32'd0);
    check("arst done", 32'(done0), 32'd0);
    check("arst out",  32'(out0),  32'd0);
    check("arst cout", 32'(cout0), 32'd0);
    check("arst ovf",  32'(ovf0),  32'd0);
    check("arst zero", 32'(zero0), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("arst nodone", 32'(done0), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("postrst", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    sweep1();
    sweep2();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder/subtractor: a WIDTH-bit add or subtract computed DIGIT bits per clock through a single DIGIT-wide ripple stage, with a start/busy/done handshake. It produces carry/borrow, signed overflow and zero flags, and has a real borrow output in subtract mode. It sits in the ALU datapath wherever a wide add/sub is needed and area matters more than latency.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT is the number of digit cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- sub  in  1  0 = add, 1 = subtract; latched with start.
- num1  in  WIDTH  operand A; latched with start.
- num2  in  WIDTH  operand B; latched with start.
- cin  in  1  carry-in (add) or borrow-in (sub); latched with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: results valid.
- out  out  WIDTH  result.
- cout  out  1  final carry out. In subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  out == 0.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with busy=0, done=0, out=0, cout=0, ovf=0, zero=0, and clears the digit counter and all internal registers.
- IDLE or DONE with start=1, at the edge:
  - latch A=num1;
  - latch B=num2 for add, or B=~num2 for sub;
  - set carry=cin for add, or carry=~cin for sub;
  - counter=0; go to RUN.
- The resulting computation is A+B+cin for add and num1−num2−cin for sub.
- RUN, each edge:
  - add the low DIGIT bits of A and B plus the carry register;
  - store the carry-out;
  - shift A and B right by DIGIT;
  - shift the DIGIT sum bits into the MSB end of the result shift register;
  - counter++.
- On the edge that processes digit N−1, go to DONE and update the outputs:
  - out = completed result;
  - cout = carry out of bit WIDTH−1;
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1;
  - zero = (out==0).
- DONE lasts exactly one cycle with done=1. Next state is RUN if start=1, else IDLE.
- out, cout, ovf and zero hold their values from the DONE edge until the next DONE edge or reset. They do not change during a following RUN.
- start while in RUN is ignored. Operands are not re-sampled.
- Reset asserted mid-RUN aborts the operation immediately (asynchronous). No done pulse is produced and outputs go to their reset values.
- Degenerate case DIGIT=WIDTH (N=1): one RUN edge, then DONE.

## Timing
- Latency: start sampled at edge E0. Digits are processed at E1…EN. After EN: done=1, outputs valid. Result is available N+1 cycles after start.
- busy=1 from after E0 through the cycle before EN. busy=0 in DONE and IDLE.
- Throughput: back-to-back operations, with start held or asserted in the DONE cycle, run one every N+1 cycles.
- No combinational path from inputs to outputs. All outputs are registered.
- The carry chain spans only DIGIT bits per cycle. Critical path is about one DIGIT-bit ripple plus a mux.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 (N=4) unless stated.
- Add 0x1234+0x0FED, cin=0 → out=0x2221, cout=0, ovf=0, zero=0. done pulses exactly 5 cycles after the start edge. busy is high for 4 cycles.
- Add 0xFFFF+0x0001, cin=0 → out=0x0000, cout=1, ovf=0, zero=1. Add 0x7FFF+0x0001 → out=0x8000, cout=0, ovf=1.
- Sub 0x0003−0x0005, cin=0 → out=0xFFFE, cout=0 (borrow), ovf=0. Sub 0x8000−0x0001 → out=0x7FFF, cout=1, ovf=1. Sub 0x0005−0x0003, cin=1 → out=0x0001, cout=1.
- Handshake:
  - start pulsed again mid-RUN with different operands → ignored; the first result is unchanged.
  - start held high through DONE → a second operation begins immediately, and done pulses every 5 cycles.
- rst asserted asynchronously at the 2nd RUN edge → all outputs 0 at once, no done pulse. A new start after rst deasserts computes 0x0001+0x0001=0x0002 correctly.
- Parameter sweep: (WIDTH=16, DIGIT=16) and (WIDTH=8, DIGIT=1) against a random golden add/sub model, 1000 vectors each, checking all flags and latencies of 2 and 9 cycles respectively.
